// File: rtl/sample_packet_fifo_if.sv
// Purpose: 32-bit AXI-stream bundle shared by the input and output sides of
//          sample_packet_fifo.
// Signals: tvalid/tdata/tstrb/tlast travel from master to slave, tready travels
//          back. tstrb is only meaningful on the output side; the input side
//          does not look at it.
interface sample_packet_fifo_if #(
    parameter int DATA_WIDTH = 32
) ();
    logic                      tvalid;
    logic [DATA_WIDTH-1:0]     tdata;
    logic [DATA_WIDTH/8-1:0]   tstrb;
    logic                      tlast;
    logic                      tready;

    modport master (output tvalid, output tdata, output tstrb, output tlast, input tready);
    modport slave  (input tvalid, input tdata, input tlast, output tready);
endinterface

// File: rtl/sample_packet_fifo.sv
// Purpose: store-and-forward packet buffer for the sample-emitting peripherals.
//          Checks framing (word 0 type, word 1 size in bytes, tlast closes the
//          packet) and only forwards complete, well-formed packets. Bad or
//          overflowing packets are dropped whole and counted.
// Ports:   clk, resetn        clock, synchronous active-low reset
//          s_axis (slave)     input stream, never backpressures after reset
//          m_axis (master)    output stream, tstrb tied to all-ones
//          pkt_count          packets committed (wraps)
//          drop_count         packets dropped (wraps)
//          err_flags          sticky {overflow, size, short}
//          clear_errors       one-cycle pulse clearing err_flags
//
// Write FSM states:
//   state     | meaning
//   W_HDR0    | waiting for word 0 (sample type)
//   W_HDR1    | waiting for word 1 (size in bytes)
//   W_BODY    | storing payload until tlast
//   W_DISCARD | packet already dropped, swallowing beats until tlast
module sample_packet_fifo #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDR_WIDTH    = 9,
    parameter int MAX_PKT_WORDS = 64,
    parameter int COUNT_WIDTH   = 32
) (
    input  logic                    clk,
    input  logic                    resetn,
    sample_packet_fifo_if.slave     s_axis,
    sample_packet_fifo_if.master    m_axis,
    output logic [COUNT_WIDTH-1:0]  pkt_count,
    output logic [COUNT_WIDTH-1:0]  drop_count,
    output logic [2:0]              err_flags,
    input  logic                    clear_errors
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int PW    = ADDR_WIDTH + 1;

    typedef logic [PW-1:0] ptr_t;

    localparam ptr_t                  DEPTH_P     = ptr_t'(DEPTH);
    localparam ptr_t                  MAX_WORDS_P = ptr_t'(MAX_PKT_WORDS);
    localparam logic [DATA_WIDTH-1:0] MIN_BYTES   = DATA_WIDTH'(8);
    localparam logic [DATA_WIDTH-1:0] MAX_BYTES   = DATA_WIDTH'(4 * MAX_PKT_WORDS);

    typedef enum logic [1:0] {
        W_HDR0    = 2'd0,
        W_HDR1    = 2'd1,
        W_BODY    = 2'd2,
        W_DISCARD = 2'd3
    } wr_state_t;

    wr_state_t state_q, state_d;

    logic [DATA_WIDTH:0]   mem [DEPTH];

    // wr_ptr runs ahead speculatively; wr_commit marks the end of the last
    // complete packet. fetch_ptr feeds the output pipeline, rd_ptr only moves
    // when a word actually leaves, so words parked in the pipeline still
    // occupy their buffer slot.
    ptr_t                  wr_ptr, wr_commit, fetch_ptr, rd_ptr;
    ptr_t                  wc_q, wc_d, wc_inc;
    logic [DATA_WIDTH-1:0] size_q, size_d, wc_bytes;
    logic                  s_ready_q;

    logic                  accept, pop, full, size_ok;
    logic                  do_store, do_commit, do_drop;
    logic [2:0]            err_set;

    logic                  pf_v, out_v;
    logic [DATA_WIDTH-1:0] pf_data, out_data;
    logic                  pf_last, out_last;
    logic                  out_take, pf_to_out, pf_free, fetch_en;
    logic [DATA_WIDTH:0]   rd_word;

    assign accept   = s_axis.tvalid && s_ready_q;
    assign pop      = out_v && m_axis.tready;
    // A word leaving this cycle frees its slot for this cycle's write.
    assign full     = ((wr_ptr - rd_ptr) == DEPTH_P) && !pop;
    assign wc_inc   = wc_q + ptr_t'(1);
    assign wc_bytes = DATA_WIDTH'({wc_inc, 2'b00});
    assign size_ok  = (s_axis.tdata[1:0] == 2'b00) && (s_axis.tdata >= MIN_BYTES)
                      && (s_axis.tdata <= MAX_BYTES);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= W_HDR0;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        wc_d      = wc_q;
        size_d    = size_q;
        do_store  = 1'b0;
        do_commit = 1'b0;
        do_drop   = 1'b0;
        err_set   = 3'b000;
        if (accept) begin
            if (state_q != W_DISCARD && full) begin
                err_set[2] = 1'b1;
                do_drop    = 1'b1;
                state_d    = s_axis.tlast ? W_HDR0 : W_DISCARD;
            end else begin
                case (state_q)
                    W_HDR0: begin
                        if (s_axis.tlast) begin
                            do_drop    = 1'b1;
                            err_set[0] = 1'b1;
                        end else begin
                            do_store = 1'b1;
                            wc_d     = ptr_t'(1);
                            state_d  = W_HDR1;
                        end
                    end
                    W_HDR1: begin
                        if (s_axis.tlast) begin
                            do_drop    = 1'b1;
                            err_set[0] = 1'b1;
                            state_d    = W_HDR0;
                        end else if (size_ok) begin
                            do_store = 1'b1;
                            size_d   = s_axis.tdata;
                            wc_d     = ptr_t'(2);
                            state_d  = W_BODY;
                        end else begin
                            do_drop    = 1'b1;
                            err_set[1] = 1'b1;
                            state_d    = W_DISCARD;
                        end
                    end
                    W_BODY: begin
                        if (s_axis.tlast) begin
                            if (wc_bytes == size_q) begin
                                do_store  = 1'b1;
                                do_commit = 1'b1;
                            end else begin
                                do_drop    = 1'b1;
                                err_set[1] = 1'b1;
                            end
                            state_d = W_HDR0;
                        end else if (wc_inc > MAX_WORDS_P) begin
                            do_drop    = 1'b1;
                            err_set[1] = 1'b1;
                            state_d    = W_DISCARD;
                        end else begin
                            do_store = 1'b1;
                            wc_d     = wc_inc;
                        end
                    end
                    default: begin
                        if (s_axis.tlast) begin
                            state_d = W_HDR0;
                        end
                    end
                endcase
            end
        end
    end

    // Storage has no reset; pointers define what is valid.
    always_ff @(posedge clk) begin
        if (do_store) begin
            mem[wr_ptr[ADDR_WIDTH-1:0]] <= {s_axis.tlast, s_axis.tdata};
        end
    end

    assign rd_word = mem[fetch_ptr[ADDR_WIDTH-1:0]];

    always_ff @(posedge clk) begin
        if (!resetn) begin
            s_ready_q  <= 1'b0;
            wr_ptr     <= '0;
            wr_commit  <= '0;
            wc_q       <= '0;
            size_q     <= '0;
            pkt_count  <= '0;
            drop_count <= '0;
            err_flags  <= 3'b000;
        end else begin
            s_ready_q <= 1'b1;
            wc_q      <= wc_d;
            size_q    <= size_d;
            if (do_drop) begin
                wr_ptr <= wr_commit;
            end else if (do_store) begin
                wr_ptr <= wr_ptr + ptr_t'(1);
            end
            if (do_commit) begin
                wr_commit <= wr_ptr + ptr_t'(1);
            end
            pkt_count  <= pkt_count + COUNT_WIDTH'(do_commit);
            drop_count <= drop_count + COUNT_WIDTH'(do_drop);
            // A new error in the same cycle as a clear keeps its flag set.
            err_flags  <= (clear_errors ? 3'b000 : err_flags) | err_set;
        end
    end

    // Output register fed by a one-entry prefetch; both can move every cycle.
    assign out_take  = !out_v || m_axis.tready;
    assign pf_to_out = pf_v && out_take;
    assign pf_free   = !pf_v || pf_to_out;
    assign fetch_en  = (fetch_ptr != wr_commit) && pf_free;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            fetch_ptr <= '0;
            rd_ptr    <= '0;
            pf_v      <= 1'b0;
            pf_data   <= '0;
            pf_last   <= 1'b0;
            out_v     <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
        end else begin
            rd_ptr <= rd_ptr + ptr_t'(pop);
            if (fetch_en) begin
                fetch_ptr <= fetch_ptr + ptr_t'(1);
                pf_v      <= 1'b1;
                pf_data   <= rd_word[DATA_WIDTH-1:0];
                pf_last   <= rd_word[DATA_WIDTH];
            end else if (pf_to_out) begin
                pf_v <= 1'b0;
            end
            if (pf_to_out) begin
                out_v    <= 1'b1;
                out_data <= pf_data;
                out_last <= pf_last;
            end else if (m_axis.tready) begin
                out_v <= 1'b0;
            end
        end
    end

    assign s_axis.tready = s_ready_q;
    assign m_axis.tvalid = out_v;
    assign m_axis.tdata  = out_data;
    assign m_axis.tlast  = out_last;
    assign m_axis.tstrb  = '1;
endmodule

// File: tb/tb_sample_packet_fifo.sv
module tb_sample_packet_fifo;
    localparam int MAXW = 64;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        resetn, s_valid, s_last, m_ready, m_ready_s, clear_errors;
    logic [31:0] s_data;
    logic [31:0] pkt_cnt, drop_cnt, pkt_cnt_s, drop_cnt_s;
    logic [2:0]  err, err_s;

    sample_packet_fifo_if #(.DATA_WIDTH(32)) s_if ();
    sample_packet_fifo_if #(.DATA_WIDTH(32)) m_if ();
    sample_packet_fifo_if #(.DATA_WIDTH(32)) s_if_s ();
    sample_packet_fifo_if #(.DATA_WIDTH(32)) m_if_s ();

    assign s_if.tvalid   = s_valid;
    assign s_if.tdata    = s_data;
    assign s_if.tlast    = s_last;
    assign s_if.tstrb    = 4'hF;
    assign s_if_s.tvalid = s_valid;
    assign s_if_s.tdata  = s_data;
    assign s_if_s.tlast  = s_last;
    assign s_if_s.tstrb  = 4'hF;
    assign m_if.tready   = m_ready;
    assign m_if_s.tready = m_ready_s;

    sample_packet_fifo dut (
        .clk(clk), .resetn(resetn), .s_axis(s_if), .m_axis(m_if),
        .pkt_count(pkt_cnt), .drop_count(drop_cnt), .err_flags(err),
        .clear_errors(clear_errors)
    );

    sample_packet_fifo #(.ADDR_WIDTH(4), .MAX_PKT_WORDS(16)) dut_small (
        .clk(clk), .resetn(resetn), .s_axis(s_if_s), .m_axis(m_if_s),
        .pkt_count(pkt_cnt_s), .drop_count(drop_cnt_s), .err_flags(err_s),
        .clear_errors(clear_errors)
    );

    int checks = 0;
    int passed = 0;
    int stall_viol = 0;
    bit rand_ready = 0;
    bit prev_stall = 0;
    logic [32:0] prev_word;
    logic [32:0] got_q[$];
    logic [32:0] got_s_q[$];
    logic [32:0] exp_q[$];

    // Output monitor: records every handshake and flags any change of a
    // stalled beat.
    always @(negedge clk) begin
        if (m_if.tvalid && m_ready) got_q.push_back({m_if.tlast, m_if.tdata});
        if (m_if_s.tvalid && m_ready_s) got_s_q.push_back({m_if_s.tlast, m_if_s.tdata});
        if (!resetn) begin
            prev_stall = 0;
        end else begin
            if (prev_stall && (!m_if.tvalid || {m_if.tlast, m_if.tdata} !== prev_word))
                stall_viol++;
            prev_stall = m_if.tvalid && !m_ready;
            prev_word  = {m_if.tlast, m_if.tdata};
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_ready) m_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic send_word(input logic [31:0] d, input logic last);
        s_valid = 1'b1;
        s_data  = d;
        s_last  = last;
        tick();
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic send_pkt(input logic [31:0] w[$], input bit gaps);
        for (int i = 0; i < w.size(); i++) begin
            if (gaps) idle($urandom_range(0, 2));
            send_word(w[i], (i == w.size() - 1));
        end
    endtask

    task automatic push_exp(input logic [31:0] w[$]);
        for (int i = 0; i < w.size(); i++) exp_q.push_back({(i == w.size() - 1), w[i]});
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        tick();
        got_q.delete();
        got_s_q.delete();
        exp_q.delete();
    endtask

    // Index of first difference between two beat streams, -1 when identical.
    function automatic int first_diff(input logic [32:0] a[$], input logic [32:0] b[$]);
        for (int i = 0; i < a.size() && i < b.size(); i++)
            if (a[i] !== b[i]) return i;
        if (a.size() != b.size()) return (a.size() < b.size()) ? a.size() : b.size();
        return -1;
    endfunction

    // Packet verdict from the framing rules: 0 commit, 1 short, 2 size error.
    function automatic int verdict(input int len, input logic [31:0] size, input int maxw);
        if (len <= 2) return 1;
        if (size[1:0] != 2'b00 || size < 8 || size > 4 * maxw) return 2;
        if (len > maxw || 4 * len != size) return 2;
        return 0;
    endfunction

    task automatic test_reset();
        resetn = 1'b0;
        idle(2);
        checks++; if (s_if.tready !== 1'b0) $display("FAIL reset_tready: got %b expected 0", s_if.tready); else passed++;
        checks++; if ({m_if.tvalid, m_if.tlast, m_if.tdata} !== 34'd0)
            $display("FAIL reset_out: got v=%b l=%b d=%h expected all 0", m_if.tvalid, m_if.tlast, m_if.tdata); else passed++;
        checks++; if ({pkt_cnt, drop_cnt, err} !== 67'd0)
            $display("FAIL reset_status: got pkt=%0d drop=%0d err=%b expected 0", pkt_cnt, drop_cnt, err); else passed++;
        resetn = 1'b1;
        tick();
        checks++; if (s_if.tready !== 1'b1) $display("FAIL ready_after_reset: got %b expected 1", s_if.tready); else passed++;
        checks++; if (m_if.tstrb !== 4'hF) $display("FAIL tstrb: got %h expected f", m_if.tstrb); else passed++;
    endtask

    task automatic test_single_packet();
        logic [31:0] w[$] = '{32'h5350_0003, 32'h0000_0014, 32'h1111_2222, 32'h3333_4444, 32'h0000_0007};
        int d;
        do_reset();
        m_ready = 1'b1;
        push_exp(w);
        send_pkt(w, 0);
        tick();
        checks++; if (m_if.tvalid !== 1'b0) $display("FAIL latency_early: got tvalid=%b expected 0", m_if.tvalid); else passed++;
        tick();
        checks++; if (m_if.tvalid !== 1'b1) $display("FAIL latency_2: got tvalid=%b expected 1", m_if.tvalid); else passed++;
        idle(10);
        d = first_diff(got_q, exp_q);
        checks++; if (d != -1) $display("FAIL single_stream: diff at beat %0d, got %0d beats expected %0d", d, got_q.size(), exp_q.size()); else passed++;
        checks++; if (pkt_cnt !== 32'd1 || drop_cnt !== 32'd0)
            $display("FAIL single_counts: got pkt=%0d drop=%0d expected 1/0", pkt_cnt, drop_cnt); else passed++;
    endtask

    task automatic test_size_error();
        logic [31:0] bad[$]  = '{32'h5350_0003, 32'h0000_0018, 32'h1, 32'h2, 32'h3};
        logic [31:0] good[$] = '{32'h5350_0004, 32'h0000_0014, 32'hA, 32'hB, 32'hC};
        int d;
        do_reset();
        send_pkt(bad, 0);
        idle(6);
        checks++; if (got_q.size() != 0) $display("FAIL size_nothing_out: got %0d beats expected 0", got_q.size()); else passed++;
        checks++; if (drop_cnt !== 32'd1 || err !== 3'b010)
            $display("FAIL size_status: got drop=%0d err=%b expected 1/010", drop_cnt, err); else passed++;
        push_exp(good);
        send_pkt(good, 0);
        idle(8);
        d = first_diff(got_q, exp_q);
        checks++; if (d != -1 || pkt_cnt !== 32'd1) $display("FAIL size_then_good: diff at %0d pkt=%0d expected -1/1", d, pkt_cnt); else passed++;
    endtask

    task automatic test_short();
        do_reset();
        send_word(32'h5350_0003, 1'b1);
        idle(5);
        checks++; if (drop_cnt !== 32'd1 || err !== 3'b001 || got_q.size() != 0)
            $display("FAIL short_status: got drop=%0d err=%b beats=%0d expected 1/001/0", drop_cnt, err, got_q.size()); else passed++;
        send_word(32'h5350_0003, 1'b0);
        send_word(32'h0000_0014, 1'b1);
        tick();
        checks++; if (drop_cnt !== 32'd2 || err !== 3'b001)
            $display("FAIL short_two_word: got drop=%0d err=%b expected 2/001", drop_cnt, err); else passed++;
        clear_errors = 1'b1;
        tick();
        clear_errors = 1'b0;
        checks++; if (err !== 3'b000) $display("FAIL clear_errors: got %b expected 000", err); else passed++;
        clear_errors = 1'b1;
        send_word(32'h5350_0003, 1'b1);
        clear_errors = 1'b0;
        checks++; if (err !== 3'b001) $display("FAIL clear_vs_error: got %b expected 001", err); else passed++;
    endtask

    task automatic test_overflow();
        logic [31:0] w[$];
        int d;
        do_reset();
        m_ready_s = 1'b0;
        for (int p = 0; p < 4; p++) begin
            w = '{32'h5350_0000 + 32'(p), 32'h0000_0014, 32'(p * 16 + 2), 32'(p * 16 + 3), 32'(p * 16 + 4)};
            if (p < 3) push_exp(w);
            send_pkt(w, 0);
        end
        idle(3);
        checks++; if (pkt_cnt_s !== 32'd3 || drop_cnt_s !== 32'd1)
            $display("FAIL ovf_counts: got pkt=%0d drop=%0d expected 3/1", pkt_cnt_s, drop_cnt_s); else passed++;
        checks++; if (err_s !== 3'b100) $display("FAIL ovf_flags: got %b expected 100", err_s); else passed++;
        checks++; if (pkt_cnt !== 32'd4) $display("FAIL ovf_big_buffer: got pkt=%0d expected 4", pkt_cnt); else passed++;
        m_ready_s = 1'b1;
        idle(30);
        m_ready_s = 1'b0;
        d = first_diff(got_s_q, exp_q);
        checks++; if (d != -1) $display("FAIL ovf_drain: diff at %0d, got %0d beats expected %0d", d, got_s_q.size(), exp_q.size()); else passed++;
    endtask

    task automatic test_back_to_back_random_ready();
        logic [31:0] w[$];
        int d;
        do_reset();
        stall_viol = 0;
        rand_ready = 1;
        for (int p = 0; p < 10; p++) begin
            w = '{32'h5350_0000 | 32'(p), 32'h0000_0014, $urandom, $urandom, $urandom};
            push_exp(w);
            send_pkt(w, p[0]);
        end
        idle(80);
        rand_ready = 0;
        m_ready = 1'b1;
        idle(10);
        d = first_diff(got_q, exp_q);
        checks++; if (d != -1) $display("FAIL rr_stream: diff at %0d, got %0d beats expected %0d", d, got_q.size(), exp_q.size()); else passed++;
        checks++; if (stall_viol != 0) $display("FAIL rr_stall_stable: got %0d changes expected 0", stall_viol); else passed++;
        checks++; if (pkt_cnt !== 32'd10) $display("FAIL rr_pkt_count: got %0d expected 10", pkt_cnt); else passed++;
    endtask

    task automatic test_random_mix();
        logic [31:0] w[$];
        logic [31:0] size;
        logic [2:0]  exp_err = 3'b000;
        int exp_pkt = 0, exp_drop = 0, len, sel, v, d;
        do_reset();
        stall_viol = 0;
        rand_ready = 1;
        for (int p = 0; p < 25; p++) begin
            len = $urandom_range(1, 10);
            sel = $urandom_range(0, 5);
            size = (sel < 3) ? 32'(4 * len) : (sel == 3) ? 32'(4 * len + 4) :
                   (sel == 4) ? 32'(4 * len - 4) : 32'($urandom_range(0, 15));
            w.delete();
            for (int i = 0; i < len; i++) w.push_back((i == 1) ? size : $urandom);
            v = verdict(len, size, MAXW);
            if (v == 0) begin exp_pkt++; push_exp(w); end
            else begin exp_drop++; exp_err[v - 1] = 1'b1; end
            send_pkt(w, 1);
        end
        idle(80);
        rand_ready = 0;
        m_ready = 1'b1;
        idle(10);
        d = first_diff(got_q, exp_q);
        checks++; if (d != -1) $display("FAIL mix_stream: diff at %0d, got %0d beats expected %0d", d, got_q.size(), exp_q.size()); else passed++;
        checks++; if (pkt_cnt !== 32'(exp_pkt) || drop_cnt !== 32'(exp_drop))
            $display("FAIL mix_counts: got pkt=%0d drop=%0d expected %0d/%0d", pkt_cnt, drop_cnt, exp_pkt, exp_drop); else passed++;
        checks++; if (err !== exp_err) $display("FAIL mix_flags: got %b expected %b", err, exp_err); else passed++;
        checks++; if (stall_viol != 0) $display("FAIL mix_stall_stable: got %0d changes expected 0", stall_viol); else passed++;
    endtask

    task automatic test_reset_mid_packet();
        logic [31:0] good[$] = '{32'h5350_0009, 32'h0000_0014, 32'hDEAD_0001, 32'hDEAD_0002, 32'hDEAD_0003};
        int d;
        do_reset();
        send_word(32'h5350_0001, 1'b0);
        send_word(32'h0000_0014, 1'b0);
        send_word(32'hBAD0_0003, 1'b0);
        do_reset();
        push_exp(good);
        send_pkt(good, 0);
        idle(8);
        d = first_diff(got_q, exp_q);
        checks++; if (d != -1) $display("FAIL mid_reset_stream: diff at %0d, got %0d beats expected %0d", d, got_q.size(), exp_q.size()); else passed++;
        checks++; if (pkt_cnt !== 32'd1 || drop_cnt !== 32'd0)
            $display("FAIL mid_reset_counts: got pkt=%0d drop=%0d expected 1/0", pkt_cnt, drop_cnt); else passed++;
    endtask

    initial begin
        resetn       = 1'b0;
        s_valid      = 1'b0;
        s_last       = 1'b0;
        s_data       = '0;
        m_ready      = 1'b1;
        m_ready_s    = 1'b0;
        clear_errors = 1'b0;
        prev_word    = '0;
        test_reset();
        test_single_packet();
        test_size_error();
        test_short();
        test_overflow();
        test_back_to_back_random_ready();
        test_random_mix();
        test_reset_mid_packet();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
